nios2pio_onchip_mem_arbiter: RTL and testbench
==============================================

# nios2pio_onchip_mem_arbiter

Two-requester controller for the system's 2048×32 single-port on-chip RAM, which has a registered address, an unregistered output, and byte enables. It shares the RAM between a primary Avalon-MM master (m0, the Nios II data path) and a secondary master (m1, the DMA/loader), using round-robin arbitration with one transaction per cycle. It can optionally zero-fill the whole RAM after reset before granting any access. It sits between the interconnect and the RAM's s1 port, and drives the RAM's chipselect, write and clken directly.

## Interface
- DEPTH, 2048, RAM words; address width AW = clog2(DEPTH) = 11
- DW, 32, data width; byte-enable width DW/8 = 4
- CLEAR_ON_RESET, 1, when 1, zero-fill every word after reset
- clk  in  1  single system clock
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  AW  word address
- m0_byteenable / m1_byteenable  in  4  byte lanes for writes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DW  write data
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata / m1_readdata  out  DW  read data
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid
- mem_address  out  AW  to RAM
- mem_byteenable  out  4  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DW  to RAM
- mem_clken  out  1  to RAM
- mem_readdata  in  DW  from RAM (valid the cycle after the address edge)
- init_busy  out  1  zero-fill in progress

## Operation
- States: INIT and RUN. Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
- INIT:
  - Counter runs 0..DEPTH-1; each cycle writes 0 to one word with byteenable 4'hF.
  - Both waitrequests are held high.
  - After the write to address DEPTH-1, the block moves to RUN and init_busy drops.
- RUN request and grant:
  - reqN = mN_read | mN_write.
  - If only one master requests, that master is granted.
  - If both request, the master not granted last is granted.
  - last_grant updates only on an accepted transaction; its reset value is m1, so m0 wins the first tie.
- The granted master gets waitrequest=0 (combinational). Its command drives the mem_* outputs with mem_chipselect=1. The loser keeps waitrequest=1 and must hold its command.
- If read and write are both high together, write wins and no readdatavalid is produced.
- A lone requester may be granted on consecutive cycles (back-to-back).
- With no grant: mem_chipselect=0 and mem_write=0. mem_address holds its last value.
- mem_clken=1 at all times outside reset.
- Read return:
  - A registered pending flag and owner id are captured on an accepted read.
  - The next cycle, mOwner_readdatavalid=1 and mOwner_readdata=mem_readdata.
  - The non-owner's readdata is 0.
- Reset mid-INIT restarts the counter at 0. Reset mid-read drops the pending readdatavalid.

## Timing
- Reset values:
  - state = INIT (or RUN if CLEAR_ON_RESET=0)
  - init_busy = CLEAR_ON_RESET
  - waitrequests = 1
  - readdatavalid = 0, readdata = 0
  - mem_chipselect = 0, mem_write = 0, mem_address = 0
  - last_grant = m1
- INIT takes exactly DEPTH cycles after reset release (2048). The first RUN grant can occur in cycle DEPTH.
- Read latency: accept at edge N gives readdatavalid in cycle N+1, for exactly 1 cycle.
- Throughput is one transaction per cycle, summed over both masters.
- Write completes at the accept edge. A read of the same address in the next cycle returns the new data.
- Under fairness with both masters continuously requesting, grants alternate m0, m1, m0, …

## Structure
- Shared constants include, nios2pio_mem_arb_defs.vh, holds:
  - DEPTH, AW and DW defaults
  - state encodings ST_INIT=1'b0 and ST_RUN=1'b1
  - owner ids OWN_M0 and OWN_M1
- One sub-module, nios2pio_rr_arb2: a 2-input round-robin grant cell. It takes req[1:0] and accept and outputs a one-hot grant[1:0], and it contains the last_grant register.
- Top level holds the INIT counter, the command mux and the read-return pipeline register.

## Test plan
- Reset with CLEAR_ON_RESET=1:
  - During cycles 0..2047, mem_write=1 with addresses 0..2047 and writedata=0, and both waitrequests are 1.
  - In cycle 2048, init_busy=0.
- Single master: m0 writes 0xDEADBEEF to 0x123 with byteenable 4'b0101, then reads 0x123.
  - Required: readdatavalid one cycle after the read accept, readdata=0x00AD00EF.
- Contention: m0 and m1 both read continuously, to 0x010 and 0x020 respectively.
  - Required: grants alternate m0, m1, m0, …, starting with m0.
  - Each readdatavalid appears only on its owner's port, one cycle after that owner's accept.
- Back-to-back: m1 issues 4 writes in consecutive cycles while m0 is idle.
  - Required: waitrequest=0 for all 4 cycles, and 4 mem_write pulses.
- Illegal command: m0_read=m0_write=1 with writedata=0x5.
  - Required: the write is performed and no readdatavalid is produced.
- Reset assertion:
  - During INIT at count 1000, the count restarts at 0 after release.
  - During a pending read, readdatavalid is never asserted.

Source files
------------

// File: rtl/nios2pio_onchip_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// nios2pio_onchip_mem_arbiter_pkg : shared sizes, state and owner encodings
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nios2pio_onchip_mem_arbiter_pkg;

    localparam int DEPTH_DEF = 2048;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);
    localparam int DW_DEF    = 32;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/nios2pio_onchip_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// nios2pio_onchip_mem_arbiter_if : one Avalon-MM master port into the arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface nios2pio_onchip_mem_arbiter_if
    import nios2pio_onchip_mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic [AW-1:0]   address;
    logic [DW/8-1:0] byteenable;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

`default_nettype wire

// File: rtl/nios2pio_rr_arb2.sv
// ----------------------------------------------------------------------------
// nios2pio_rr_arb2 : two-input round-robin grant cell holding last_grant
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nios2pio_rr_arb2
    import nios2pio_onchip_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    owner_e last_q;
    owner_e last_d;

    always_comb begin
        // On a tie the master that did not win last time goes first.
        if (req_i == 2'b11) begin
            grant_o = (last_q == OWN_M1) ? 2'b01 : 2'b10;
        end else begin
            grant_o = req_i;
        end
        last_d = last_q;
        if (accept_i) begin
            last_d = grant_o[1] ? OWN_M1 : OWN_M0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= OWN_M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nios2pio_onchip_mem_arbiter.sv
// ----------------------------------------------------------------------------
// nios2pio_onchip_mem_arbiter : shares the on-chip RAM between two masters
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nios2pio_onchip_mem_arbiter
    import nios2pio_onchip_mem_arbiter_pkg::*;
#(
    parameter int DEPTH          = DEPTH_DEF,
    parameter int DW             = DW_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int AW             = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    nios2pio_onchip_mem_arbiter_if.slave m0,
    nios2pio_onchip_mem_arbiter_if.slave m1,
    output logic [AW-1:0]           mem_address,
    output logic [DW/8-1:0]         mem_byteenable,
    output logic                    mem_chipselect,
    output logic                    mem_write,
    output logic [DW-1:0]           mem_writedata,
    output logic                    mem_clken,
    input  logic [DW-1:0]           mem_readdata,
    output logic                    init_busy
);

    localparam state_e        RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] hold_q;
    logic          rvalid_q, rvalid_d;
    owner_e        rown_q, rown_d;

    logic          w_run;
    logic [1:0]    w_req;
    logic [1:0]    w_grant;
    logic          w_accept;
    logic          w_cmd_read;

    // Gating with reset_n keeps every grant and RAM strobe quiet while in reset.
    assign w_run    = (state_q == ST_RUN) && reset_n;
    assign w_req    = {m1.read | m1.write, m0.read | m0.write} & {2{w_run}};
    assign w_accept = |w_grant;

    nios2pio_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_i    (w_req),
        .accept_i (w_accept),
        .grant_o  (w_grant)
    );

    always_comb begin
        mem_address    = hold_q;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        w_cmd_read     = 1'b0;
        if ((state_q == ST_INIT) && reset_n) begin
            mem_address    = cnt_q;
            mem_byteenable = '1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
        end else if (w_grant[0]) begin
            mem_address    = m0.address;
            mem_byteenable = m0.byteenable;
            mem_chipselect = 1'b1;
            mem_write      = m0.write;
            mem_writedata  = m0.writedata;
            w_cmd_read     = m0.read & ~m0.write;
        end else if (w_grant[1]) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_chipselect = 1'b1;
            mem_write      = m1.write;
            mem_writedata  = m1.writedata;
            w_cmd_read     = m1.read & ~m1.write;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = w_cmd_read;
        rown_d   = rown_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
        if (w_cmd_read) begin
            rown_d = w_grant[1] ? OWN_M1 : OWN_M0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RESET_STATE;
            cnt_q    <= '0;
            hold_q   <= '0;
            rvalid_q <= 1'b0;
            rown_q   <= OWN_M0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= mem_address;
            rvalid_q <= rvalid_d;
            rown_q   <= rown_d;
        end
    end

    assign m0.waitrequest   = ~w_grant[0];
    assign m1.waitrequest   = ~w_grant[1];
    assign m0.readdatavalid = rvalid_q && (rown_q == OWN_M0);
    assign m1.readdatavalid = rvalid_q && (rown_q == OWN_M1);
    assign m0.readdata      = m0.readdatavalid ? mem_readdata : '0;
    assign m1.readdata      = m1.readdatavalid ? mem_readdata : '0;
    assign mem_clken        = reset_n;
    assign init_busy        = (state_q == ST_INIT);

endmodule

`default_nettype wire

// File: tb/tb_nios2pio_onchip_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_nios2pio_onchip_mem_arbiter : vector table plus read-return scoreboard
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nios2pio_onchip_mem_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 2048;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] wd;
    } cmd_t;

    typedef struct packed {
        cmd_t c0;
        cmd_t c1;
        logic ew0;
        logic ew1;
    } vec_t;

    typedef struct packed {
        logic          own;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic          mem_clken;
    logic [DW-1:0] mem_readdata;
    logic          init_busy;

    nios2pio_onchip_mem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    nios2pio_onchip_mem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

    nios2pio_onchip_mem_arbiter #(
        .DEPTH(DEPTH), .DW(DW), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_if),
        .m1             (m1_if),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .init_busy      (init_busy)
    );

    always #5 clk = ~clk;

    // RAM: registered address, unregistered output, byte-lane writes.
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_addr_q = '0;
    always @(posedge clk) begin
        if (mem_clken) begin
            ram_addr_q <= mem_address;
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_wpulse = 0;
    logic [DW-1:0] shadow [DEPTH];
    exp_t          sb [$];
    cmd_t          cur0, cur1;
    vec_t          tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic cmd_t mk(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                input logic [3:0] be, input logic [DW-1:0] wd);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = addr; c.be = be; c.wd = wd;
        return c;
    endfunction

    task automatic apply(input cmd_t c0, input cmd_t c1);
        cur0 = c0;
        cur1 = c1;
        m0_if.read = c0.rd; m0_if.write = c0.wr; m0_if.address = c0.addr;
        m0_if.byteenable = c0.be; m0_if.writedata = c0.wd;
        m1_if.read = c1.rd; m1_if.write = c1.wr; m1_if.address = c1.addr;
        m1_if.byteenable = c1.be; m1_if.writedata = c1.wd;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic check_init(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("init_cycle",
                64'({init_busy, mem_chipselect, mem_write, m0_if.waitrequest, m1_if.waitrequest,
                     mem_byteenable, mem_address, mem_writedata}),
                64'({1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, AW'(i), 32'h0}));
            adv();
        end
    endtask

    task automatic check_cycle(input logic ew0, input logic ew1);
        exp_t          e;
        cmd_t          c;
        logic          g;
        logic          ev0, ev1;
        logic [DW-1:0] ed0, ed1;
        @(negedge clk);
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.own) begin ev1 = 1'b1; ed1 = e.data; end
            else       begin ev0 = 1'b1; ed0 = e.data; end
        end
        chk("m0_rdvalid", 64'(m0_if.readdatavalid), 64'(ev0));
        chk("m1_rdvalid", 64'(m1_if.readdatavalid), 64'(ev1));
        chk("m0_rdata",   64'(m0_if.readdata),      64'(ed0));
        chk("m1_rdata",   64'(m1_if.readdata),      64'(ed1));
        chk("m0_wait",    64'(m0_if.waitrequest),   64'(ew0));
        chk("m1_wait",    64'(m1_if.waitrequest),   64'(ew1));
        g = !ew0 || !ew1;
        c = !ew0 ? cur0 : cur1;
        chk("mem_cs", 64'(mem_chipselect), 64'(g));
        if (mem_chipselect && mem_write) n_wpulse++;
        if (g) begin
            chk("mem_write", 64'(mem_write),   64'(c.wr));
            chk("mem_addr",  64'(mem_address), 64'(c.addr));
            if (c.wr) begin
                chk("mem_wdata", 64'(mem_writedata),  64'(c.wd));
                chk("mem_be",    64'(mem_byteenable), 64'(c.be));
                for (int b = 0; b < 4; b++) begin
                    if (c.be[b]) shadow[c.addr][8*b +: 8] = c.wd[8*b +: 8];
                end
            end else if (c.rd) begin
                sb.push_back('{own: ew0, data: shadow[c.addr]});
            end
        end else begin
            chk("mem_write_idle", 64'(mem_write), 64'(0));
        end
    endtask

    initial begin
        cmd_t IDLE;
        IDLE = mk(1'b0, 1'b0, '0, 4'h0, '0);
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

        // Contention, then mixed traffic; masters hold their command while waiting.
        tbl[0]  = '{mk(1,0,11'h010,4'hF,0), mk(1,0,11'h020,4'hF,0), 1'b0, 1'b1};
        tbl[1]  = '{mk(1,0,11'h010,4'hF,0), mk(1,0,11'h020,4'hF,0), 1'b1, 1'b0};
        tbl[2]  = '{mk(1,0,11'h010,4'hF,0), mk(1,0,11'h020,4'hF,0), 1'b0, 1'b1};
        tbl[3]  = '{mk(1,0,11'h010,4'hF,0), mk(1,0,11'h020,4'hF,0), 1'b1, 1'b0};
        tbl[4]  = '{mk(1,0,11'h010,4'hF,0), mk(1,0,11'h020,4'hF,0), 1'b0, 1'b1};
        tbl[5]  = '{mk(1,0,11'h010,4'hF,0), mk(1,0,11'h020,4'hF,0), 1'b1, 1'b0};
        tbl[6]  = '{mk(0,1,11'h020,4'hF,32'h11223344), IDLE, 1'b0, 1'b1};
        tbl[7]  = '{IDLE, mk(1,0,11'h020,4'hF,0), 1'b1, 1'b0};
        tbl[8]  = '{IDLE, IDLE, 1'b1, 1'b1};
        tbl[9]  = '{mk(1,0,11'h020,4'hF,0), mk(0,1,11'h010,4'b1100,32'hCAFEF00D), 1'b0, 1'b1};
        tbl[10] = '{mk(1,0,11'h010,4'hF,0), mk(0,1,11'h010,4'b1100,32'hCAFEF00D), 1'b1, 1'b0};
        tbl[11] = '{mk(1,0,11'h010,4'hF,0), IDLE, 1'b0, 1'b1};
        tbl[12] = '{IDLE, IDLE, 1'b1, 1'b1};

        reset_n = 1'b0;
        apply(IDLE, IDLE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_waits",  64'({m0_if.waitrequest, m1_if.waitrequest}), 64'(2'b11));
        chk("rst_rdv",    64'({m0_if.readdatavalid, m1_if.readdatavalid}), 64'(2'b00));
        chk("rst_rdata",  64'({m0_if.readdata, m1_if.readdata}), 64'(0));
        chk("rst_mem",    64'({mem_chipselect, mem_write, mem_address}), 64'(0));
        chk("rst_busy",   64'(init_busy), 64'(1));
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Zero-fill interrupted by reset at count 1000.
        check_init(1000);
        @(negedge clk);
        chk("init_cnt_1000", 64'(mem_address), 64'(1000));
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_init_addr", 64'(mem_address), 64'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        apply(mk(1,0,11'h7FF,4'hF,0), mk(0,1,11'h001,4'hF,32'h1));
        check_init(DEPTH);
        apply(IDLE, IDLE);
        check_cycle(1'b1, 1'b1);
        chk("busy_after_init", 64'(init_busy), 64'(0));
        chk("clken_run",       64'(mem_clken), 64'(1));
        adv();

        for (int v = 0; v < 13; v++) begin
            apply(tbl[v].c0, tbl[v].c1);
            check_cycle(tbl[v].ew0, tbl[v].ew1);
            adv();
        end

        // Byte-lane write then read-back on m0.
        apply(mk(0,1,11'h123,4'b0101,32'hDEADBEEF), IDLE);
        check_cycle(1'b0, 1'b1); adv();
        apply(mk(1,0,11'h123,4'hF,0), IDLE);
        check_cycle(1'b0, 1'b1); adv();
        apply(IDLE, IDLE);
        check_cycle(1'b1, 1'b1);
        chk("be_merge_rdata", 64'(m0_if.readdata), 64'(32'h00AD00EF));
        adv();

        // Back-to-back writes from m1 alone.
        n_wpulse = 0;
        for (int k = 0; k < 4; k++) begin
            apply(IDLE, mk(0,1,AW'(11'h200 + k),4'hF,32'h1000 + k));
            check_cycle(1'b1, 1'b0); adv();
        end
        chk("b2b_pulses", 64'(n_wpulse), 64'(4));
        apply(IDLE, mk(1,0,11'h202,4'hF,0));
        check_cycle(1'b1, 1'b0); adv();
        apply(IDLE, IDLE);
        check_cycle(1'b1, 1'b1); adv();

        // Read and write together: write wins, no read return.
        apply(mk(1,1,11'h300,4'hF,32'h5), IDLE);
        check_cycle(1'b0, 1'b1); adv();
        apply(mk(1,0,11'h300,4'hF,0), IDLE);
        check_cycle(1'b0, 1'b1); adv();
        apply(IDLE, IDLE);
        check_cycle(1'b1, 1'b1); adv();

        // Reset while a read is pending.
        apply(mk(1,0,11'h123,4'hF,0), IDLE);
        check_cycle(1'b0, 1'b1); adv();
        reset_n = 1'b0;
        apply(IDLE, IDLE);
        @(negedge clk);
        chk("rst_pending_rdv",   64'({m0_if.readdatavalid, m1_if.readdatavalid}), 64'(2'b00));
        chk("rst_pending_rdata", 64'(m0_if.readdata), 64'(0));
        sb.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        check_init(DEPTH);
        check_cycle(1'b1, 1'b1);
        chk("busy_after_reinit", 64'(init_busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
